reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
Parametrised general-purpose register file for the pipelined datapath. Successor to the single-write, fixed 32x32 file.
- Adds a second write port for a long-latency unit (mul/div) alongside the main writeback port.
- Adds same-cycle write-to-read forwarding from both write ports.
- Adds a per-register pending scoreboard, so decode can tell whether each operand is valid.

Parameters:
DATA_W, 32, width of each register and of the data ports.
ADDR_W, 5, register address width; depth is 2**ADDR_W.
ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never pending.

Ports:
Clk  input  1  clock; all state updates on the rising edge.
Rst  input  1  synchronous, active-high reset.
RA1  input  ADDR_W  read address, port 1.
RA2  input  ADDR_W  read address, port 2.
RD1  output  DATA_W  read data, port 1 (combinational).
RD2  output  DATA_W  read data, port 2 (combinational).
RV1  output  1  operand 1 valid (not pending, or forwarded this cycle).
RV2  output  1  operand 2 valid.
WE0  input  1  write enable, port 0 (main writeback).
WA0  input  ADDR_W  write address, port 0.
WD0  input  DATA_W  write data, port 0.
WE1  input  1  write enable, port 1 (long-latency unit).
WA1  input  ADDR_W  write address, port 1.
WD1  input  DATA_W  write data, port 1.
IssueEn  input  1  mark register IssueA as pending.
IssueA  input  ADDR_W  destination register being issued.
Flush  input  1  clear all pending bits.
PendCnt  output  ADDR_W+1  number of registers currently pending.

Behaviour:
- Storage: 2**ADDR_W registers of DATA_W bits, plus one pending bit per register.
- Reset: on a rising edge with Rst=1, all registers and pending bits go to 0. WE0/WE1/IssueEn/Flush in that cycle are ignored.
  - Post-reset outputs: RD1=RD2=0 (for any address, absent forwarding), RV1=RV2=1, PendCnt=0.
  - Rst asserted mid-operation discards all pending state; nothing is replayed.
- Write:
  - At the edge, for each port n with WEn=1 (and WAn!=0 when ZERO_REG=1), reg[WAn] <= WDn.
  - WE0 and WE1 to the same address in the same cycle: port 1 wins.
- Read, combinational, priority per port:
  1. ZERO_REG=1 and RA==0 -> 0.
  2. WE1=1 and WA1==RA (and WA1 writable) -> WD1.
  3. WE0=1 and WA0==RA (and writable) -> WD0.
  4. Otherwise reg[RA].
  - Forwarding latency 0: data written in cycle N is visible on RD in cycle N combinationally, and from the array from N+1.
- Scoreboard, next-state per register r, evaluated in this priority order:
  1. Rst -> 0.
  2. IssueEn and IssueA==r (writable) -> 1.
  3. Flush -> 0.
  4. A write (either port) to r -> 0.
  5. Otherwise hold.
  - Consequences:
    - Issue and write to the same register in the same cycle: pending stays 1 (new producer outstanding).
    - Flush together with IssueEn: every other register clears; IssueA is set.
    - Issue to a register that is already pending: stays 1, not counted twice.
- RVn, combinational:
  - 1 if ZERO_REG=1 and RAn==0.
  - Else 1 if the RAn read is forwarded this cycle (rule 2 or 3 hits).
  - Else the inverse of pending[RAn].
- PendCnt: combinational population count of the pending bits. Range 0..2**ADDR_W (0..2**ADDR_W-1 when ZERO_REG=1).
- ZERO_REG=0: register 0 behaves like every other register.
- No X propagation: all outputs are defined for every address from the first cycle after reset.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, assert Rst one cycle -> next cycle RA1=5 gives RD1=0, RV1=1, PendCnt=0.
- Forwarding priority: same cycle WE0 (r3, 0x11111111) and WE1 (r3, 0x22222222), RA1=3 -> RD1=0x22222222 that cycle; next cycle array r3=0x22222222.
- Zero register: WE0 to r0 with 0xFFFFFFFF, IssueEn to r0 -> RD1(RA1=0)=0, RV1=1, PendCnt unchanged at 0.
- Scoreboard lifecycle: IssueEn r7 -> next cycle RV2(RA2=7)=0, PendCnt=1; WE1 r7 with 0xABCD -> same cycle RV2=1 and RD2=0xABCD; next cycle pending cleared, PendCnt=0.
- Issue/write collision: r9 pending; same cycle WE0 r9 and IssueEn r9 -> r9 data updated, pending stays 1, PendCnt=1.
- Flush with issue: r1, r2 and r4 pending; Flush with IssueEn r6 -> next cycle only r6 pending, PendCnt=1; repeat with ADDR_W=3, DATA_W=16 to check parametrisation.

Source files
------------

// File: rtl/reg_file_sb.sv
// Parametrised register file with two write ports, zero-latency write-to-read forwarding
// and a per-register pending scoreboard for operand-valid tracking.
`timescale 1ns/1ps
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              RV1,
    output logic              RV2,
    input  logic              WE0,
    input  logic [ADDR_W-1:0] WA0,
    input  logic [DATA_W-1:0] WD0,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] WA1,
    input  logic [DATA_W-1:0] WD1,
    input  logic              IssueEn,
    input  logic [ADDR_W-1:0] IssueA,
    input  logic              Flush,
    output logic [ADDR_W:0]   PendCnt
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [DEPTH-1:0] ONE_HOT0 = {{(DEPTH-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_pend;

    logic              w_wr0, w_wr1, w_iss;
    logic [DEPTH-1:0]  w_clr, w_set, w_pend_nxt;
    logic [DATA_W-1:0] w_rd1, w_rd2;
    logic              w_rv1, w_rv2;
    logic [ADDR_W:0]   w_cnt;

    // Register 0 is hard-wired when ZERO_REG is set, so its writes and issues are dropped here.
    assign w_wr0 = WE0     && ((ZERO_REG == 0) || (WA0    != '0));
    assign w_wr1 = WE1     && ((ZERO_REG == 0) || (WA1    != '0));
    assign w_iss = IssueEn && ((ZERO_REG == 0) || (IssueA != '0));

    assign w_clr = (w_wr0 ? (ONE_HOT0 << WA0) : '0) | (w_wr1 ? (ONE_HOT0 << WA1) : '0);
    assign w_set = w_iss ? (ONE_HOT0 << IssueA) : '0;

    // Issue dominates flush and write-back: a fresh producer is outstanding.
    assign w_pend_nxt = w_set | (Flush ? '0 : (r_pend & ~w_clr));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_pend <= '0;
        end else begin
            if (w_wr0) r_mem[WA0] <= WD0;
            if (w_wr1) r_mem[WA1] <= WD1;
            r_pend <= w_pend_nxt;
        end
    end

    always_comb begin
        w_rd1 = r_mem[RA1];
        w_rv1 = ~r_pend[RA1];
        if (w_wr0 && (WA0 == RA1)) begin
            w_rd1 = WD0;
            w_rv1 = 1'b1;
        end
        if (w_wr1 && (WA1 == RA1)) begin
            w_rd1 = WD1;
            w_rv1 = 1'b1;
        end
        if ((ZERO_REG != 0) && (RA1 == '0)) begin
            w_rd1 = '0;
            w_rv1 = 1'b1;
        end
    end

    always_comb begin
        w_rd2 = r_mem[RA2];
        w_rv2 = ~r_pend[RA2];
        if (w_wr0 && (WA0 == RA2)) begin
            w_rd2 = WD0;
            w_rv2 = 1'b1;
        end
        if (w_wr1 && (WA1 == RA2)) begin
            w_rd2 = WD1;
            w_rv2 = 1'b1;
        end
        if ((ZERO_REG != 0) && (RA2 == '0)) begin
            w_rd2 = '0;
            w_rv2 = 1'b1;
        end
    end

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt = w_cnt + {{ADDR_W{1'b0}}, r_pend[i]};
        end
    end

    assign RD1     = w_rd1;
    assign RD2     = w_rd2;
    assign RV1     = w_rv1;
    assign RV2     = w_rv2;
    assign PendCnt = w_cnt;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios plus randomized traffic against an array/scoreboard model,
// and a second small instance (ADDR_W=3, DATA_W=16) for parametrisation.
`timescale 1ns/1ps
module tb_reg_file_sb;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int N   = 32;
    localparam int BDW = 16;
    localparam int BAW = 3;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic          Rst = 1'b1;
    logic [AW-1:0] RA1 = '0, RA2 = '0, WA0 = '0, WA1 = '0, IssueA = '0;
    logic [DW-1:0] WD0 = '0, WD1 = '0;
    logic          WE0 = 1'b0, WE1 = 1'b0, IssueEn = 1'b0, Flush = 1'b0;
    logic [DW-1:0] RD1, RD2;
    logic          RV1, RV2;
    logic [AW:0]   PendCnt;

    logic           b_Rst = 1'b1;
    logic [BAW-1:0] b_RA1 = '0, b_RA2 = '0, b_WA0 = '0, b_WA1 = '0, b_IssueA = '0;
    logic [BDW-1:0] b_WD0 = '0, b_WD1 = '0;
    logic           b_WE0 = 1'b0, b_WE1 = 1'b0, b_IssueEn = 1'b0, b_Flush = 1'b0;
    logic [BDW-1:0] b_RD1, b_RD2;
    logic           b_RV1, b_RV2;
    logic [BAW:0]   b_PendCnt;

    int errors = 0;
    int checks = 0;

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
        .Clk(Clk), .Rst(Rst), .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2), .RV1(RV1), .RV2(RV2),
        .WE0(WE0), .WA0(WA0), .WD0(WD0), .WE1(WE1), .WA1(WA1), .WD1(WD1),
        .IssueEn(IssueEn), .IssueA(IssueA), .Flush(Flush), .PendCnt(PendCnt)
    );

    reg_file_sb #(.DATA_W(BDW), .ADDR_W(BAW), .ZERO_REG(1)) dut_b (
        .Clk(Clk), .Rst(b_Rst), .RA1(b_RA1), .RA2(b_RA2), .RD1(b_RD1), .RD2(b_RD2), .RV1(b_RV1), .RV2(b_RV2),
        .WE0(b_WE0), .WA0(b_WA0), .WD0(b_WD0), .WE1(b_WE1), .WA1(b_WA1), .WD1(b_WD1),
        .IssueEn(b_IssueEn), .IssueA(b_IssueA), .Flush(b_Flush), .PendCnt(b_PendCnt)
    );

    // Reference model: architectural register contents and pending flags.
    logic [DW-1:0] m_reg [N];
    bit            m_pend [N];

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] ra);
        if (ra == 0) return '0;
        if (WE1 && WA1 == ra) return WD1;
        if (WE0 && WA0 == ra) return WD0;
        return m_reg[ra];
    endfunction

    function automatic logic exp_rv(input logic [AW-1:0] ra);
        if (ra == 0) return 1'b1;
        if ((WE1 && WA1 == ra) || (WE0 && WA0 == ra)) return 1'b1;
        return !m_pend[ra];
    endfunction

    function automatic int exp_cnt();
        int c = 0;
        for (int r = 0; r < N; r++) c += int'(m_pend[r]);
        return c;
    endfunction

    task automatic model_commit();
        bit nxt [N];
        if (Rst) begin
            for (int r = 0; r < N; r++) begin
                m_reg[r]  = '0;
                m_pend[r] = 1'b0;
            end
        end else begin
            for (int r = 1; r < N; r++) begin
                if (IssueEn && IssueA == r)                     nxt[r] = 1'b1;
                else if (Flush)                                 nxt[r] = 1'b0;
                else if ((WE0 && WA0 == r) || (WE1 && WA1 == r)) nxt[r] = 1'b0;
                else                                            nxt[r] = m_pend[r];
            end
            for (int r = 1; r < N; r++) m_pend[r] = nxt[r];
            if (WE0 && WA0 != 0) m_reg[WA0] = WD0;
            if (WE1 && WA1 != 0) m_reg[WA1] = WD1;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_commit();
    endtask

    task automatic idle_a();
        Rst = 1'b0; WE0 = 1'b0; WE1 = 1'b0; IssueEn = 1'b0; Flush = 1'b0;
    endtask

    task automatic idle_b();
        b_Rst = 1'b0; b_WE0 = 1'b0; b_WE1 = 1'b0; b_IssueEn = 1'b0; b_Flush = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge Clk); Rst = 1'b1; b_Rst = 1'b1; tick();
        @(negedge Clk); idle_a(); idle_b();
        WE0 = 1'b1; WA0 = 5'd5; WD0 = 32'hDEADBEEF; RA1 = 5'd5; #1;
        checks++; if (RD1 !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_fwd_rd1 got=%h exp=%h", RD1, 32'hDEADBEEF); end
        tick();
        @(negedge Clk); idle_a(); IssueEn = 1'b1; IssueA = 5'd12; #1;
        checks++; if (RD1 !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_arr_rd1 got=%h exp=%h", RD1, 32'hDEADBEEF); end
        tick();
        @(negedge Clk); idle_a(); RA2 = 5'd12; #1;
        checks++; if (RV2 !== 1'b0 || PendCnt !== 6'd1) begin errors++; $display("FAIL rst_pre_pend got rv2=%b cnt=%0d exp rv2=0 cnt=1", RV2, PendCnt); end
        Rst = 1'b1; tick();
        @(negedge Clk); idle_a(); #1;
        checks++; if (RD1 !== 32'h0 || RV1 !== 1'b1) begin errors++; $display("FAIL rst_rd1 got rd1=%h rv1=%b exp rd1=0 rv1=1", RD1, RV1); end
        checks++; if (RV2 !== 1'b1 || PendCnt !== 6'd0) begin errors++; $display("FAIL rst_pend got rv2=%b cnt=%0d exp rv2=1 cnt=0", RV2, PendCnt); end
        tick();
        for (int a = 0; a < N; a++) begin
            @(negedge Clk); RA1 = AW'(a); RA2 = AW'(N - 1 - a); #1;
            checks++;
            if (RD1 !== '0 || RD2 !== '0 || RV1 !== 1'b1 || RV2 !== 1'b1) begin
                errors++; $display("FAIL rst_sweep a=%0d got rd1=%h rd2=%h rv1=%b rv2=%b exp 0 0 1 1", a, RD1, RD2, RV1, RV2);
            end
            tick();
        end
    endtask

    task automatic test_forward_priority();
        @(negedge Clk); idle_a();
        WE0 = 1'b1; WA0 = 5'd3; WD0 = 32'h11111111;
        WE1 = 1'b1; WA1 = 5'd3; WD1 = 32'h22222222; RA1 = 5'd3; #1;
        checks++; if (RD1 !== 32'h22222222 || RV1 !== 1'b1) begin errors++; $display("FAIL fwd_prio got rd1=%h rv1=%b exp 22222222 1", RD1, RV1); end
        tick();
        @(negedge Clk); WA0 = 5'd8; WD0 = 32'h00000808; WA1 = 5'd10; WD1 = 32'h00001010; RA2 = 5'd10; #1;
        checks++; if (RD1 !== 32'h22222222) begin errors++; $display("FAIL fwd_arr_r3 got=%h exp=22222222", RD1); end
        RA1 = 5'd8; #1;
        checks++; if (RD1 !== 32'h00000808 || RD2 !== 32'h00001010) begin errors++; $display("FAIL fwd_split got rd1=%h rd2=%h exp 00000808 00001010", RD1, RD2); end
        tick();
    endtask

    task automatic test_zero_reg();
        @(negedge Clk); idle_a();
        WE0 = 1'b1; WA0 = 5'd0; WD0 = 32'hFFFFFFFF; WE1 = 1'b1; WA1 = 5'd0; WD1 = 32'hFFFFFFFF;
        IssueEn = 1'b1; IssueA = 5'd0; RA1 = 5'd0; #1;
        checks++; if (RD1 !== 32'h0 || RV1 !== 1'b1) begin errors++; $display("FAIL zero_fwd got rd1=%h rv1=%b exp 0 1", RD1, RV1); end
        tick();
        @(negedge Clk); idle_a(); #1;
        checks++; if (RD1 !== 32'h0 || RV1 !== 1'b1 || PendCnt !== 6'd0) begin errors++; $display("FAIL zero_after got rd1=%h rv1=%b cnt=%0d exp 0 1 0", RD1, RV1, PendCnt); end
        tick();
    endtask

    task automatic test_scoreboard();
        @(negedge Clk); idle_a(); IssueEn = 1'b1; IssueA = 5'd7; tick();
        @(negedge Clk); idle_a(); RA2 = 5'd7; #1;
        checks++; if (RV2 !== 1'b0 || PendCnt !== 6'd1 || RD2 !== 32'h0) begin errors++; $display("FAIL sb_issue got rv2=%b cnt=%0d rd2=%h exp 0 1 0", RV2, PendCnt, RD2); end
        WE1 = 1'b1; WA1 = 5'd7; WD1 = 32'h0000ABCD; #1;
        checks++; if (RV2 !== 1'b1 || RD2 !== 32'h0000ABCD || PendCnt !== 6'd1) begin errors++; $display("FAIL sb_wb got rv2=%b rd2=%h cnt=%0d exp 1 0000abcd 1", RV2, RD2, PendCnt); end
        tick();
        @(negedge Clk); idle_a(); #1;
        checks++; if (RV2 !== 1'b1 || PendCnt !== 6'd0 || RD2 !== 32'h0000ABCD) begin errors++; $display("FAIL sb_clear got rv2=%b cnt=%0d rd2=%h exp 1 0 0000abcd", RV2, PendCnt, RD2); end
        tick();
    endtask

    task automatic test_issue_write_collision();
        @(negedge Clk); idle_a(); IssueEn = 1'b1; IssueA = 5'd9; tick();
        @(negedge Clk); WE0 = 1'b1; WA0 = 5'd9; WD0 = 32'h99990000; RA1 = 5'd9; #1;
        checks++; if (RD1 !== 32'h99990000 || RV1 !== 1'b1) begin errors++; $display("FAIL coll_fwd got rd1=%h rv1=%b exp 99990000 1", RD1, RV1); end
        tick();
        @(negedge Clk); idle_a(); IssueEn = 1'b1; IssueA = 5'd9; #1;
        checks++; if (RD1 !== 32'h99990000 || RV1 !== 1'b0 || PendCnt !== 6'd1) begin errors++; $display("FAIL coll_pend got rd1=%h rv1=%b cnt=%0d exp 99990000 0 1", RD1, RV1, PendCnt); end
        tick();
        @(negedge Clk); idle_a(); #1;
        checks++; if (PendCnt !== 6'd1) begin errors++; $display("FAIL coll_reissue got cnt=%0d exp 1", PendCnt); end
        Flush = 1'b1; tick();
    endtask

    task automatic test_flush_issue();
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk); idle_a(); IssueEn = 1'b1; IssueA = (k == 0) ? 5'd1 : (k == 1) ? 5'd2 : 5'd4; tick();
        end
        @(negedge Clk); idle_a(); #1;
        checks++; if (PendCnt !== 6'd3) begin errors++; $display("FAIL fl_pre got cnt=%0d exp 3", PendCnt); end
        Flush = 1'b1; IssueEn = 1'b1; IssueA = 5'd6; tick();
        @(negedge Clk); idle_a(); RA1 = 5'd6; RA2 = 5'd1; #1;
        checks++; if (PendCnt !== 6'd1 || RV1 !== 1'b0 || RV2 !== 1'b1) begin errors++; $display("FAIL fl_post got cnt=%0d rv1=%b rv2=%b exp 1 0 1", PendCnt, RV1, RV2); end
        RA1 = 5'd2; RA2 = 5'd4; #1;
        checks++; if (RV1 !== 1'b1 || RV2 !== 1'b1) begin errors++; $display("FAIL fl_others got rv1=%b rv2=%b exp 1 1", RV1, RV2); end
        Flush = 1'b1; tick();
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, N - 1));
        return AW'($urandom_range(0, 7));
    endfunction

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            @(negedge Clk);
            Rst     = ($urandom_range(0, 149) == 0);
            Flush   = ($urandom_range(0, 24) == 0);
            WE0     = ($urandom_range(0, 1) == 1);
            WE1     = ($urandom_range(0, 2) == 0);
            IssueEn = ($urandom_range(0, 2) != 0);
            WA0 = rnd_addr(); WA1 = rnd_addr(); IssueA = rnd_addr();
            RA1 = rnd_addr(); RA2 = rnd_addr();
            WD0 = $urandom; WD1 = $urandom;
            #1;
            checks++;
            if (RD1 !== exp_rd(RA1) || RV1 !== exp_rv(RA1)) begin
                errors++; $display("FAIL rnd_p1 cyc=%0d ra=%0d got %h/%b exp %h/%b", c, RA1, RD1, RV1, exp_rd(RA1), exp_rv(RA1));
            end
            checks++;
            if (RD2 !== exp_rd(RA2) || RV2 !== exp_rv(RA2)) begin
                errors++; $display("FAIL rnd_p2 cyc=%0d ra=%0d got %h/%b exp %h/%b", c, RA2, RD2, RV2, exp_rd(RA2), exp_rv(RA2));
            end
            checks++;
            if (int'(PendCnt) != exp_cnt()) begin
                errors++; $display("FAIL rnd_cnt cyc=%0d got %0d exp %0d", c, PendCnt, exp_cnt());
            end
            tick();
        end
        @(negedge Clk); idle_a();
    endtask

    task automatic test_param();
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk); idle_b(); b_IssueEn = 1'b1; b_IssueA = (k == 0) ? 3'd1 : (k == 1) ? 3'd2 : 3'd4; tick();
        end
        @(negedge Clk); idle_b(); #1;
        checks++; if (b_PendCnt !== 4'd3) begin errors++; $display("FAIL p_pre got cnt=%0d exp 3", b_PendCnt); end
        b_Flush = 1'b1; b_IssueEn = 1'b1; b_IssueA = 3'd6; tick();
        @(negedge Clk); idle_b(); b_RA1 = 3'd6; b_RA2 = 3'd4; #1;
        checks++; if (b_PendCnt !== 4'd1 || b_RV1 !== 1'b0 || b_RV2 !== 1'b1) begin errors++; $display("FAIL p_flush got cnt=%0d rv1=%b rv2=%b exp 1 0 1", b_PendCnt, b_RV1, b_RV2); end
        b_WE0 = 1'b1; b_WA0 = 3'd6; b_WD0 = 16'h1234; b_WE1 = 1'b1; b_WA1 = 3'd6; b_WD1 = 16'hBEEF; #1;
        checks++; if (b_RD1 !== 16'hBEEF || b_RV1 !== 1'b1) begin errors++; $display("FAIL p_fwd got rd1=%h rv1=%b exp beef 1", b_RD1, b_RV1); end
        tick();
        @(negedge Clk); idle_b(); #1;
        checks++; if (b_RD1 !== 16'hBEEF || b_PendCnt !== 4'd0) begin errors++; $display("FAIL p_arr got rd1=%h cnt=%0d exp beef 0", b_RD1, b_PendCnt); end
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk); idle_b(); b_IssueEn = 1'b1; b_IssueA = BAW'(i); tick();
        end
        @(negedge Clk); idle_b(); #1;
        checks++; if (b_PendCnt !== 4'd7) begin errors++; $display("FAIL p_full got cnt=%0d exp 7", b_PendCnt); end
        b_Flush = 1'b1; tick();
        @(negedge Clk); idle_b();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_forward_priority();
        test_zero_reg();
        test_scoreboard();
        test_issue_write_collision();
        test_flush_issue();
        test_random();
        test_param();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
